// File: rtl/trace_packer_if.sv
// trace_packer_if: retired-instruction trace stream in, packed FIFO read port out
interface trace_packer_if #(parameter int C_FIFO_AWIDTH = 9);
   logic                     trace_valid_instr;
   logic [31:0]              trace_pc;
   logic [31:0]              trace_instruction;
   logic                     trace_data_access;
   logic                     trace_data_write;
   logic [31:0]              trace_data_address;
   logic [31:0]              trace_data_write_value;
   logic                     dfifo_rd;
   logic [31:0]              dfifo_data;
   logic [1:0]               dfifo_tag;
   logic                     dfifo_valid;
   logic [C_FIFO_AWIDTH:0]   dfifo_status;
   modport master (
      output trace_valid_instr, trace_pc, trace_instruction, trace_data_access,
             trace_data_write, trace_data_address, trace_data_write_value, dfifo_rd,
      input  dfifo_data, dfifo_tag, dfifo_valid, dfifo_status
   );
   modport slave (
      input  trace_valid_instr, trace_pc, trace_instruction, trace_data_access,
             trace_data_write, trace_data_address, trace_data_write_value, dfifo_rd,
      output dfifo_data, dfifo_tag, dfifo_valid, dfifo_status
   );
endinterface

// File: rtl/trace_packer.sv
// trace_packer: triggered trace capture, packs events into a tagged FWFT FIFO
module trace_packer #(
   parameter int C_FIFO_AWIDTH  = 9,
   parameter int C_POST_WIDTH   = 16,
   parameter int C_INCLUDE_DATA = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   trace_packer_if.slave           tp,
   input  logic                    collect_in,
   input  logic                    trigger_in,
   input  logic                    include_data,
   input  logic [C_POST_WIDTH-1:0] post_count,
   output logic                    dfifo_reset,
   output logic                    collect_out,
   output logic                    trigger_out,
   output logic [15:0]             drop_count
);
   localparam logic [C_FIFO_AWIDTH:0] DEPTH = (C_FIFO_AWIDTH+1)'(1) << C_FIFO_AWIDTH;
   typedef enum logic [1:0] {IDLE, ARMED, TRIGGERED, DONE} state_t;
   state_t                    state, state_nx;
   logic                      trig_q;
   logic [C_POST_WIDTH-1:0]   cnt;
   logic [31:0]               stg [4];
   logic [2:0]                stg_idx, stg_len, len_nx;
   logic [33:0]               mem [2**C_FIFO_AWIDTH];
   logic [C_FIFO_AWIDTH-1:0]  wp, rp;
   logic [C_FIFO_AWIDTH:0]    fcnt;
   logic flush, post, open_in, tedge, busy, full, push, last, accept, drop, pop, de, dacc, dwr, valid;
   // state register, trigger edge history, post counter and drop counter
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state      <= IDLE;
         trig_q     <= 1'b0;
         cnt        <= '0;
         drop_count <= '0;
      end else begin
         state      <= state_nx;
         trig_q     <= trigger_in;
         cnt        <= flush ? '0 : (state == ARMED && tedge) ? post_count :
                       (state == TRIGGERED && accept) ? cnt - C_POST_WIDTH'(1) : cnt;
         drop_count <= (state == IDLE && collect_in) ? '0 :
                       (drop && drop_count != 16'hFFFF) ? drop_count + 16'd1 : drop_count;
      end
   // next state: dropping collect_in from any active state flushes back to IDLE
   always_comb
      state_nx = flush ? IDLE :
                 (state == IDLE && collect_in) ? ARMED :
                 (state == ARMED && tedge) ? TRIGGERED :
                 (state == TRIGGERED && cnt == '0) ? DONE : state;
   // FSM outputs and the first-word-fall-through head of the FIFO
   always_comb begin
      collect_out     = state == ARMED || state == TRIGGERED;
      trigger_out     = post;
      dfifo_reset     = flush;
      valid           = post && fcnt != '0;
      tp.dfifo_valid  = valid;
      tp.dfifo_data   = valid ? mem[rp][31:0] : '0;
      tp.dfifo_tag    = valid ? mem[rp][33:32] : '0;
      tp.dfifo_status = fcnt;
   end
   // acceptance, staging drain and FIFO write/pop decisions
   always_comb begin
      flush   = state != IDLE && !collect_in;
      post    = state == TRIGGERED || state == DONE;
      open_in = state == ARMED || (state == TRIGGERED && cnt != '0);
      tedge   = trigger_in && !trig_q;
      busy    = stg_idx != stg_len;
      full    = fcnt == DEPTH;
      push    = busy && !(post && full);
      last    = push && (stg_idx + 3'd1 == stg_len);
      accept  = tp.trace_valid_instr && open_in && (!busy || last);
      drop    = tp.trace_valid_instr && open_in && busy && !last;
      pop     = post && fcnt != '0 && tp.dfifo_rd;
      de      = (C_INCLUDE_DATA != 0) && include_data;
      dacc    = de && tp.trace_data_access;
      dwr     = dacc && tp.trace_data_write;
      len_nx  = 3'd2 + 3'(dacc) + 3'(dwr);
   end
   // staging progress: index walks up to the event length, equal means empty
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         stg_idx <= '0;
         stg_len <= '0;
      end else if (flush) begin
         stg_idx <= '0;
         stg_len <= '0;
      end else if (accept) begin
         stg_idx <= '0;
         stg_len <= len_nx;
      end else if (push)
         stg_idx <= stg_idx + 3'd1;
   // staging payload, word position doubles as its tag
   always_ff @(posedge clk)
      if (accept) begin
         stg[0] <= tp.trace_pc;
         stg[1] <= tp.trace_instruction;
         stg[2] <= tp.trace_data_address;
         stg[3] <= tp.trace_data_write_value;
      end
   // FIFO pointers; a write into a full pre-trigger FIFO overwrites the oldest word
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wp   <= '0;
         rp   <= '0;
         fcnt <= '0;
      end else if (flush) begin
         wp   <= '0;
         rp   <= '0;
         fcnt <= '0;
      end else begin
         if (push) wp <= wp + C_FIFO_AWIDTH'(1);
         if (pop || (push && full)) rp <= rp + C_FIFO_AWIDTH'(1);
         fcnt <= (push && !full && !pop) ? fcnt + (C_FIFO_AWIDTH+1)'(1) :
                 (pop && !(push && !full)) ? fcnt - (C_FIFO_AWIDTH+1)'(1) : fcnt;
      end
   // FIFO storage
   always_ff @(posedge clk)
      if (push) mem[wp] <= {stg_idx[1:0], stg[stg_idx[1:0]]};
endmodule

// File: doc/trace_packer.md
TRACE_PACKER -- requirements
Module: trace_packer

Interface
REQ-001 Parameter C_FIFO_AWIDTH, default 9, FIFO address width; depth = 2**C_FIFO_AWIDTH words.
REQ-002 Parameter C_POST_WIDTH, default 16, width of post-trigger event counter.
REQ-003 Parameter C_INCLUDE_DATA, default 1; 0 suppresses all data-address/data-value words.
REQ-004 Clk  in  1  sole clock, all logic rising-edge.
REQ-005 Rst_n  in  1  asynchronous, active-low reset.
REQ-006 Trace_Valid_Instr  in  1  instruction retired this cycle (event).
REQ-007 Trace_PC, Trace_Instruction  in  32 each  event PC / opcode.
REQ-008 Trace_Data_Access, Trace_Data_Write  in  1 each  event has load/store; store.
REQ-009 Trace_Data_Address, Trace_Data_Write_Value  in  32 each  data address / store value.
REQ-010 collect_in  in  1  level; arms capture.  trigger_in  in  1  rising edge triggers.
REQ-011 include_data  in  1  runtime enable for data words (ANDed with C_INCLUDE_DATA).
REQ-012 Post_Count  in  C_POST_WIDTH  events captured after trigger.
REQ-013 dfifo_rd  in  1  reader pop request.
REQ-014 dfifo_data  out  32 payload; dfifo_tag  out  2 (00 PC, 01 instr, 10 daddr, 11 dvalue).
REQ-015 dfifo_valid  out  1; dfifo_status  out  C_FIFO_AWIDTH+1  word count.
REQ-016 dfifo_reset  out  1  one-cycle flush pulse; collect_out, trigger_out  out  1 each.
REQ-017 drop_count  out  16  events dropped, saturating.

Function
REQ-018 States IDLE, ARMED, TRIGGERED, DONE; collect_out=1 in ARMED/TRIGGERED; trigger_out=1 in TRIGGERED/DONE.
REQ-019 IDLE->ARMED when collect_in=1; drop_count cleared on that transition.
REQ-020 ARMED->TRIGGERED on trigger_in rising edge (registered previous value); counter loads Post_Count; edges outside ARMED ignored.
REQ-021 TRIGGERED->DONE when counter reaches 0; Post_Count=0 gives DONE on next edge with no post events.
REQ-022 Any non-IDLE state with collect_in=0 -> IDLE; dfifo_reset=1 for that one cycle; FIFO, staging, counter flushed; drop_count held.
REQ-023 Event accepted when state (start of cycle) is ARMED/TRIGGERED, Trace_Valid_Instr=1, staging empty or emitting its last word this cycle.
REQ-024 Accepted event loads staging on that edge: PC, instr, then daddr if data enabled and Trace_Data_Access, then dvalue if also Trace_Data_Write; 2-4 words.
REQ-025 Valid event not accepted (staging busy) increments drop_count, saturating at 16'hFFFF.
REQ-026 Each accepted event in TRIGGERED decrements counter by 1; the event whose decrement reaches 0 is fully emitted.
REQ-027 In DONE no new events accepted; staging finishes its in-flight event.
REQ-028 Staging writes one word per cycle, first word on the edge after load (latency 1 edge).
REQ-029 FIFO first-word-fall-through: dfifo_valid=1 iff count>0 and state TRIGGERED/DONE; dfifo_data/tag show head.
REQ-030 Pop on edge when dfifo_valid & dfifo_rd; dfifo_rd with dfifo_valid=0 ignored.
REQ-031 TRIGGERED/DONE, FIFO full: staging write stalls (holds word), even if a pop occurs same cycle.
REQ-032 ARMED, FIFO full: oldest word discarded and new word written same edge; count stays at depth (circular pre-trigger).
REQ-033 Partial event at FIFO head allowed after REQ-032 discard; reader resyncs on tag 00.
REQ-034 Simultaneous write and pop, not full: count unchanged, order preserved.
REQ-035 dfifo_status exact after every edge, range 0..2**C_FIFO_AWIDTH.

Reset
REQ-036 Rst_n=0 asynchronously: state IDLE, FIFO empty, staging empty, counter 0, drop_count 0.
REQ-037 During reset: dfifo_valid, dfifo_reset, collect_out, trigger_out = 0; dfifo_status = 0; dfifo_data, dfifo_tag = 0.
REQ-038 Reset deassertion mid-capture resumes in IDLE; ARMED requires collect_in=1 on a later edge.

Verification
REQ-039 collect_in=1, trigger edge, Post_Count=3, 3 events (no data) 5 cycles apart -> 6 words tags 00,01 x3; DONE; status=6.
REQ-040 include_data=1, one store event -> 4 words tags 00,01,10,11, payloads match PC/instr/addr/value.
REQ-041 Events on consecutive cycles, no data -> every second event dropped; drop_count counts them.
REQ-042 C_FIFO_AWIDTH=3, ARMED, 6 events (12 words) then trigger -> status=8, head = word 5 (tag 00, event 3 PC).
REQ-043 TRIGGERED, FIFO full, dfifo_rd held 0 -> staging stalls, status=8; one pop -> next word written following edge.
REQ-044 collect_in drops in TRIGGERED with 5 words queued -> dfifo_reset one cycle, status=0, IDLE; Rst_n pulse mid-drain -> all outputs 0.
